exception_ctrl: RTL and testbench
=================================

# exception_ctrl

Precise-exception and interrupt arbiter sitting directly upstream of CP0, at the memory-stage/commit boundary of the five-stage MIPS pipeline.
- Samples the exception flags carried by the instruction in MEM, together with synchronised hardware interrupts and the CP0 Status/Cause/EPC read-back.
- Selects one event by fixed priority.
- Drives the CP0 write vector (BadVAddr, Status, Cause, EPC) and the pipeline flush/redirect.
- Handles ERET the same way.

## Interface
Parameters:
- WIDTH, 32, datapath width
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- mem_valid  in  1  MEM-stage instruction is valid
- mem_pc  in  WIDTH  PC of MEM instruction
- mem_in_delay_slot  in  1  MEM instruction is in a branch delay slot
- mem_addr  in  WIDTH  data address of MEM load/store
- exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades, is_eret  in  1 each  exception flags of MEM instruction
- hw_int  in  6  asynchronous hardware interrupt lines
- timer_int  in  1  CP0 timer interrupt, OR-ed into hw_int[5] after synchronisation
- status_data, cause_data, epc_data  in  WIDTH  CP0 read-back
- cp0_we  out  WIDTH  CP0 write-enable vector; only bits 8, 12, 13, 14 used
- cp0_badaddr, cp0_epc  out  WIDTH  values for BadVAddr / EPC
- cp0_exc_code  out  5  ExcCode
- cp0_branch_delay  out  1  BD flag; CP0 subtracts 4 from EPC when set
- cp0_int_enable  out  8  Status.IM to write back, always the current status_data[15:8]
- cp0_exl, cp0_ie  out  1  Status.EXL/IE to write
- flush  out  1  kill IF..MEM, one-cycle pulse
- redirect_valid  out  1  one-cycle pulse, coincident with flush
- redirect_pc  out  WIDTH  new fetch PC
- busy  out  1  high in COMMIT and SETTLE; the hazard unit stalls ID/EX on it

## Operation
- **Interrupt synchroniser.** 2-FF synchroniser on {hw_int[5] | timer_int, hw_int[4:0]}, giving int_sync[5:0].
- **Interrupt pending.** ip = {int_sync, cause_data[9:8]}. Pending when all hold:
  - status_data[0] = 1
  - status_data[1] = 0
  - |(ip & status_data[15:8]) = 1
- **Take condition.** An event is taken only in IDLE with mem_valid = 1.
- **Priority and resulting ExcCode / BadVAddr**, highest first:
  - interrupt: 0x00
  - exc_adel_if: 0x04, badaddr = mem_pc
  - exc_ri: 0x0A
  - exc_ov: 0x0C
  - exc_sys: 0x08
  - exc_bp: 0x09
  - exc_adel_ld: 0x04, badaddr = mem_addr
  - exc_ades: 0x05, badaddr = mem_addr
  - is_eret
- **Exception or interrupt taken:**
  - cp0_we bits 12 and 13 set.
  - bit 14 set only if status_data[1] = 0; with EXL already set, EPC is preserved.
  - bit 8 set only for the AdEL/AdES cases.
  - cp0_exl = 1; cp0_ie = status_data[0].
  - cp0_epc = mem_pc; cp0_branch_delay = mem_in_delay_slot.
  - redirect_pc = EXC_VECTOR.
- **ERET with no exception flag:**
  - cp0_we bit 12 only; cp0_exl = 0; cp0_ie = status_data[0].
  - redirect_pc = epc_data.
- **ERET together with any exception flag:** the exception wins.
- **FSM states:**
  - IDLE: take condition true → COMMIT.
  - COMMIT: registered outputs asserted for exactly one cycle → SETTLE.
  - SETTLE: all outputs 0; mem_valid ignored so CP0 Status can update → IDLE.
- Every FSM transition is unconditional except IDLE → COMMIT.
- **Outputs outside COMMIT:** every cp0_*, flush, redirect_valid and redirect_pc is 0.

## Timing
- **Detect-to-action latency.** Detection is combinational from IDLE inputs. cp0_we, flush and redirect are registered: asserted the cycle after sampling. CP0 registers update at the end of COMMIT.
- **Interrupt latency.** hw_int to pending takes 2 cycles of synchroniser latency plus the take cycle.
- **Blind window.** 2 cycles (COMMIT + SETTLE) between consecutive taken events.
- **Reset values.** All outputs 0, state IDLE, synchroniser flops 0.
- **Reset mid-COMMIT/SETTLE.** Immediately IDLE with all outputs 0. No partial CP0 write survives, since outputs are flop-driven and cleared asynchronously.
- **Simultaneous interrupt and exception flag.** Interrupt wins: ExcCode 0, cp0_we[8] = 0.
- **mem_valid = 0.** Flags are ignored, including interrupts; an interrupt waits for a valid instruction.
- **EXL = 1.** Interrupts are masked; synchronous exceptions are still taken, with EPC not written.

## Structure
- **Shared package `cpu_defs`:**
  - ExcCode constants: EXC_INT, EXC_ADEL, EXC_ADES, EXC_RI, EXC_OV, EXC_SYS, EXC_BP
  - CP0 register index constants: BADVADDR = 8, STATUS = 12, CAUSE = 13, EPC = 14
  - EXC_VECTOR
  - FSM state enum
- **Sub-module `int_sync`:** 6-bit 2-FF synchroniser with async active-low reset.
- **Top-level contents:** the priority encoder and the FSM stay in this module.

## Test plan
- **Load address error.** exc_adel_ld = 1, mem_addr = 0x80000003, mem_pc = 0xBFC00100, status = 0x0040FF01 → next cycle:
  - cp0_we = 0x00007100, exc_code 0x04, badaddr 0x80000003
  - flush = 1, redirect_pc 0xBFC00380
  - busy for 2 cycles
- **Interrupt beats exception.** hw_int[2] = 1 held, with exc_ov = 1 in the same cycle, status = 0x0000FF01 → 3rd cycle after assertion:
  - exc_code 0x00, cp0_we[8] = 0, cp0_exl = 1
- **ERET.** is_eret = 1, epc_data = 0xBFC00200, status = 0x0000FF03 → cp0_we = 0x00001000, cp0_exl = 0, redirect_pc 0xBFC00200.
- **Delay-slot exception and EXL masking.** exc_sys in a delay slot with status = 0x0000FF02 (EXL = 1) → cp0_we = 0x00003000 with no EPC write, cp0_branch_delay = 1; a concurrent hw_int is ignored.
- **Back-to-back and reset.**
  - Back-to-back flags on consecutive cycles → the second is ignored during SETTLE.
  - rst = 0 asserted during COMMIT → all outputs 0 within the same cycle, state IDLE.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 exception codes, CP0 register indices,
// the exception vector and the exception-controller FSM state type.
package cpu_defs;

    // ExcCode values written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // CP0 register numbers, also the bit positions in the CP0 write-enable vector
    localparam int BADVADDR = 8;
    localparam int STATUS   = 12;
    localparam int CAUSE    = 13;
    localparam int EPC      = 14;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_SETTLE = 2'd2
    } exc_state_e;

endpackage

// File: rtl/exception_ctrl_if.sv
// Bundle between the MEM/commit boundary, CP0 and the exception controller.
// slave: the exception controller; master: whatever drives the MEM side.
interface exception_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             mem_valid;
    logic [WIDTH-1:0] mem_pc;
    logic             mem_in_delay_slot;
    logic [WIDTH-1:0] mem_addr;
    logic             exc_adel_if;
    logic             exc_ri;
    logic             exc_ov;
    logic             exc_sys;
    logic             exc_bp;
    logic             exc_adel_ld;
    logic             exc_ades;
    logic             is_eret;
    logic [5:0]       hw_int;
    logic             timer_int;
    logic [WIDTH-1:0] status_data;
    logic [WIDTH-1:0] cause_data;
    logic [WIDTH-1:0] epc_data;

    logic [WIDTH-1:0] cp0_we;
    logic [WIDTH-1:0] cp0_badaddr;
    logic [WIDTH-1:0] cp0_epc;
    logic [4:0]       cp0_exc_code;
    logic             cp0_branch_delay;
    logic [7:0]       cp0_int_enable;
    logic             cp0_exl;
    logic             cp0_ie;
    logic             flush;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             busy;

    modport slave (
        input  mem_valid, mem_pc, mem_in_delay_slot, mem_addr,
        input  exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades, is_eret,
        input  hw_int, timer_int, status_data, cause_data, epc_data,
        output cp0_we, cp0_badaddr, cp0_epc, cp0_exc_code, cp0_branch_delay,
        output cp0_int_enable, cp0_exl, cp0_ie, flush, redirect_valid, redirect_pc, busy
    );

    modport master (
        output mem_valid, mem_pc, mem_in_delay_slot, mem_addr,
        output exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades, is_eret,
        output hw_int, timer_int, status_data, cause_data, epc_data,
        input  cp0_we, cp0_badaddr, cp0_epc, cp0_exc_code, cp0_branch_delay,
        input  cp0_int_enable, cp0_exl, cp0_ie, flush, redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/int_sync.sv
// Two-flop synchroniser for the asynchronous interrupt lines.
module int_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // First flop may go metastable; second flop gives a clean level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// Precise exception / interrupt arbiter at the MEM-commit boundary.
// Picks one event by fixed priority, then drives a one-cycle registered
// CP0 write and pipeline flush/redirect, followed by a settle cycle.
module exception_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = cpu_defs::EXC_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    exception_ctrl_if.slave   bus
);
    import cpu_defs::*;

    exc_state_e       state_q, state_d;
    logic [5:0]       int_sync_q;
    logic [7:0]       ip;
    logic             int_pending;
    logic             any_exc;
    logic             take;

    logic [WIDTH-1:0] nx_we, nx_bad, nx_epc, nx_rpc;
    logic [4:0]       nx_code;
    logic             nx_bd, nx_exl, nx_ie;

    logic [WIDTH-1:0] we_q, bad_q, epc_q, rpc_q;
    logic [4:0]       code_q;
    logic [7:0]       im_q;
    logic             bd_q, exl_q, ie_q, flush_q;

    logic             unused_bits;
    assign unused_bits = ^{bus.cause_data[WIDTH-1:10], bus.cause_data[7:0],
                           bus.status_data[WIDTH-1:16], bus.status_data[7:2]};

    // Timer interrupt shares the IP7 line with hw_int[5]
    int_sync #(.W(6)) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in ({bus.hw_int[5] | bus.timer_int, bus.hw_int[4:0]}),
        .sync_out (int_sync_q)
    );

    assign ip          = {int_sync_q, bus.cause_data[9:8]};
    assign int_pending = bus.status_data[0] & ~bus.status_data[1] & (|(ip & bus.status_data[15:8]));
    assign any_exc     = bus.exc_adel_if | bus.exc_ri | bus.exc_ov | bus.exc_sys |
                         bus.exc_bp | bus.exc_adel_ld | bus.exc_ades;
    assign take        = (state_q == ST_IDLE) & bus.mem_valid & (int_pending | any_exc | bus.is_eret);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: only IDLE waits; COMMIT and SETTLE each last one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Priority encoder: interrupt first, then synchronous exceptions, then ERET
    always_comb begin
        nx_we   = '0;
        nx_bad  = '0;
        nx_epc  = '0;
        nx_rpc  = '0;
        nx_code = EXC_INT;
        nx_bd   = 1'b0;
        nx_exl  = 1'b0;
        nx_ie   = 1'b0;
        if (int_pending | any_exc) begin
            nx_we[STATUS] = 1'b1;
            nx_we[CAUSE]  = 1'b1;
            // With EXL already set the original EPC must survive
            nx_we[EPC]    = ~bus.status_data[1];
            nx_exl        = 1'b1;
            nx_ie         = bus.status_data[0];
            nx_epc        = bus.mem_pc;
            nx_bd         = bus.mem_in_delay_slot;
            nx_rpc        = EXC_VECTOR;
            if (int_pending) begin
                nx_code = EXC_INT;
            end else if (bus.exc_adel_if) begin
                nx_code          = EXC_ADEL;
                nx_bad           = bus.mem_pc;
                nx_we[BADVADDR]  = 1'b1;
            end else if (bus.exc_ri) begin
                nx_code = EXC_RI;
            end else if (bus.exc_ov) begin
                nx_code = EXC_OV;
            end else if (bus.exc_sys) begin
                nx_code = EXC_SYS;
            end else if (bus.exc_bp) begin
                nx_code = EXC_BP;
            end else if (bus.exc_adel_ld) begin
                nx_code          = EXC_ADEL;
                nx_bad           = bus.mem_addr;
                nx_we[BADVADDR]  = 1'b1;
            end else begin
                nx_code          = EXC_ADES;
                nx_bad           = bus.mem_addr;
                nx_we[BADVADDR]  = 1'b1;
            end
        end else if (bus.is_eret) begin
            nx_we[STATUS] = 1'b1;
            nx_exl        = 1'b0;
            nx_ie         = bus.status_data[0];
            nx_rpc        = bus.epc_data;
        end
    end

    // Output registers: loaded only on the take edge, so they are non-zero exactly in COMMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= '0;
            bad_q   <= '0;
            epc_q   <= '0;
            rpc_q   <= '0;
            code_q  <= '0;
            im_q    <= '0;
            bd_q    <= 1'b0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            flush_q <= 1'b0;
        end else if (take) begin
            we_q    <= nx_we;
            bad_q   <= nx_bad;
            epc_q   <= nx_epc;
            rpc_q   <= nx_rpc;
            code_q  <= nx_code;
            im_q    <= bus.status_data[15:8];
            bd_q    <= nx_bd;
            exl_q   <= nx_exl;
            ie_q    <= nx_ie;
            flush_q <= 1'b1;
        end else begin
            we_q    <= '0;
            bad_q   <= '0;
            epc_q   <= '0;
            rpc_q   <= '0;
            code_q  <= '0;
            im_q    <= '0;
            bd_q    <= 1'b0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            flush_q <= 1'b0;
        end
    end

    assign bus.cp0_we           = we_q;
    assign bus.cp0_badaddr      = bad_q;
    assign bus.cp0_epc          = epc_q;
    assign bus.cp0_exc_code     = code_q;
    assign bus.cp0_branch_delay = bd_q;
    assign bus.cp0_int_enable   = im_q;
    assign bus.cp0_exl          = exl_q;
    assign bus.cp0_ie           = ie_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_valid   = flush_q;
    assign bus.redirect_pc      = rpc_q;
    assign bus.busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with an expected-result queue.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exception_ctrl_if #(.WIDTH(32)) bus ();

    exception_ctrl #(.WIDTH(32), .EXC_VECTOR(VEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] we;
        logic [4:0]  code;
        logic [31:0] bad;
        logic [31:0] epc;
        logic        bd;
        logic [7:0]  im;
        logic        exl;
        logic        ie;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    function automatic exp_t mk(input logic [31:0] we, input logic [4:0] code,
                                input logic [31:0] bad, input logic [31:0] epc,
                                input logic bd, input logic [7:0] im,
                                input logic exl, input logic ie, input logic [31:0] rpc);
        exp_t e;
        e.we = we; e.code = code; e.bad = bad; e.epc = epc; e.bd = bd;
        e.im = im; e.exl = exl; e.ie = ie; e.rpc = rpc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [7:0] f);
        {bus.exc_adel_if, bus.exc_ri, bus.exc_ov, bus.exc_sys,
         bus.exc_bp, bus.exc_adel_ld, bus.exc_ades, bus.is_eret} = f;
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy);
        chk({tag, ".busy"},  32'(bus.busy), 32'(exp_busy));
        chk({tag, ".flush"}, 32'(bus.flush), 32'd0);
        chk({tag, ".rvld"},  32'(bus.redirect_valid), 32'd0);
        chk({tag, ".we"},    bus.cp0_we, 32'd0);
        chk({tag, ".rpc"},   bus.redirect_pc, 32'd0);
        chk({tag, ".exl"},   32'(bus.cp0_exl), 32'd0);
    endtask

    // Wait (bounded) for the commit pulse, pop the expected entry and compare
    task automatic expect_commit(input string tag);
        exp_t e;
        int   waited;
        bit   seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 8) begin
            @(negedge clk);
            waited++;
            if (bus.flush === 1'b1) seen = 1'b1;
        end
        e = sb_q.pop_front();
        chk({tag, ".taken"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, ".latency"}, 32'(waited), 32'd1);
            chk({tag, ".we"},      bus.cp0_we, e.we);
            chk({tag, ".code"},    32'(bus.cp0_exc_code), 32'(e.code));
            chk({tag, ".bad"},     bus.cp0_badaddr, e.bad);
            chk({tag, ".epc"},     bus.cp0_epc, e.epc);
            chk({tag, ".bd"},      32'(bus.cp0_branch_delay), 32'(e.bd));
            chk({tag, ".im"},      32'(bus.cp0_int_enable), 32'(e.im));
            chk({tag, ".exl"},     32'(bus.cp0_exl), 32'(e.exl));
            chk({tag, ".ie"},      32'(bus.cp0_ie), 32'(e.ie));
            chk({tag, ".rpc"},     bus.redirect_pc, e.rpc);
            chk({tag, ".rvld"},    32'(bus.redirect_valid), 32'd1);
            chk({tag, ".busy"},    32'(bus.busy), 32'd1);
        end
    endtask

    // Present one MEM instruction for one cycle, check COMMIT then SETTLE then IDLE
    task automatic run_event(input string tag, input logic [7:0] f, input logic [31:0] pc,
                             input logic [31:0] addr, input logic [31:0] status,
                             input logic ds, input exp_t e);
        sb_q.push_back(e);
        bus.mem_pc            = pc;
        bus.mem_addr          = addr;
        bus.status_data       = status;
        bus.mem_in_delay_slot = ds;
        set_flags(f);
        bus.mem_valid         = 1'b1;
        expect_commit(tag);
        bus.mem_valid         = 1'b0;
        bus.mem_in_delay_slot = 1'b0;
        set_flags(8'h00);
        @(negedge clk);
        check_quiet({tag, ".settle"}, 1'b1);
        @(negedge clk);
        check_quiet({tag, ".idle"}, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Flag vector order: {adel_if, ri, ov, sys, bp, adel_ld, ades, eret}
    initial begin
        rst                   = 1'b0;
        bus.mem_valid         = 1'b0;
        bus.mem_pc            = '0;
        bus.mem_in_delay_slot = 1'b0;
        bus.mem_addr          = '0;
        bus.hw_int            = '0;
        bus.timer_int         = 1'b0;
        bus.status_data       = '0;
        bus.cause_data        = '0;
        bus.epc_data          = '0;
        set_flags(8'h00);
        repeat (2) @(negedge clk);
        check_quiet("reset", 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Load address error
        run_event("adel_ld", 8'b0000_0100, 32'hBFC00100, 32'h80000003, 32'h0040FF01, 1'b0,
                  mk(32'h00007100, 5'h04, 32'h80000003, 32'hBFC00100, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));

        // Interrupt waits for a valid instruction, then beats a concurrent exception
        bus.status_data = 32'h0000FF01;
        bus.hw_int      = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("int_wait.busy", 32'(bus.busy), 32'd0);
        end
        run_event("int_vs_ov", 8'b0010_0000, 32'hBFC00120, 32'h0, 32'h0000FF01, 1'b0,
                  mk(32'h00007000, 5'h00, 32'h0, 32'hBFC00120, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));
        bus.hw_int = '0;
        repeat (3) @(negedge clk);

        // EXL set masks interrupts even with a valid instruction present
        bus.status_data = 32'h0000FF03;
        bus.hw_int      = 6'h3F;
        bus.timer_int   = 1'b1;
        bus.mem_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("exl_mask.flush", 32'(bus.flush), 32'd0);
        end
        bus.mem_valid = 1'b0;

        // ERET
        bus.epc_data = 32'hBFC00200;
        run_event("eret", 8'b0000_0001, 32'hBFC00140, 32'h0, 32'h0000FF03, 1'b0,
                  mk(32'h00001000, 5'h00, 32'h0, 32'h0, 1'b0, 8'hFF, 1'b0, 1'b1, 32'hBFC00200));

        // Syscall in a delay slot with EXL set: no EPC write, interrupts ignored
        run_event("sys_ds_exl", 8'b0001_0000, 32'hBFC00204, 32'h0, 32'h0000FF02, 1'b1,
                  mk(32'h00003000, 5'h08, 32'h0, 32'hBFC00204, 1'b1, 8'hFF, 1'b1, 1'b0, VEC));
        bus.hw_int    = '0;
        bus.timer_int = 1'b0;
        repeat (3) @(negedge clk);

        // Fetch address error outranks load address error; BadVAddr is the PC
        run_event("adel_if", 8'b1000_0100, 32'hBFC00301, 32'h12345678, 32'h0000FF01, 1'b0,
                  mk(32'h00007100, 5'h04, 32'hBFC00301, 32'hBFC00301, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));
        run_event("ades", 8'b0000_0010, 32'hBFC00310, 32'h80001002, 32'h0000AA00, 1'b0,
                  mk(32'h00007100, 5'h05, 32'h80001002, 32'hBFC00310, 1'b0, 8'hAA, 1'b1, 1'b0, VEC));
        // ERET with an exception flag: the exception wins
        run_event("eret_ov", 8'b0010_0001, 32'hBFC00320, 32'h0, 32'h0000FF03, 1'b0,
                  mk(32'h00003000, 5'h0C, 32'h0, 32'hBFC00320, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));
        run_event("bp", 8'b0000_1000, 32'hBFC00330, 32'h0, 32'h0000FF00, 1'b0,
                  mk(32'h00007000, 5'h09, 32'h0, 32'hBFC00330, 1'b0, 8'hFF, 1'b1, 1'b0, VEC));

        // Back-to-back: second instruction arrives during COMMIT/SETTLE and is dropped
        sb_q.push_back(mk(32'h00007000, 5'h0A, 32'h0, 32'hBFC00340, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));
        bus.status_data = 32'h0000FF01;
        bus.mem_pc      = 32'hBFC00340;
        set_flags(8'b0100_0000);
        bus.mem_valid   = 1'b1;
        expect_commit("b2b_first");
        bus.mem_pc = 32'hBFC00344;
        set_flags(8'b0000_1000);
        @(negedge clk);
        check_quiet("b2b_settle", 1'b1);
        @(negedge clk);
        check_quiet("b2b_idle", 1'b0);
        bus.mem_valid = 1'b0;
        set_flags(8'h00);
        @(negedge clk);
        check_quiet("b2b_after", 1'b0);

        // Reset asserted in the middle of COMMIT clears everything at once
        sb_q.push_back(mk(32'h00007000, 5'h0C, 32'h0, 32'hBFC00350, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));
        bus.mem_pc    = 32'hBFC00350;
        set_flags(8'b0010_0000);
        bus.mem_valid = 1'b1;
        expect_commit("pre_rst");
        bus.mem_valid = 1'b0;
        set_flags(8'h00);
        #1 rst = 1'b0;
        #1;
        check_quiet("rst_commit", 1'b0);
        chk("rst_commit.code", 32'(bus.cp0_exc_code), 32'd0);
        chk("rst_commit.epc",  bus.cp0_epc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("post_rst", 1'b0);

        // Controller is back in IDLE and takes the next event immediately
        run_event("post_rst_bp", 8'b0000_1000, 32'hBFC00360, 32'h0, 32'h0000FF01, 1'b0,
                  mk(32'h00007000, 5'h09, 32'h0, 32'hBFC00360, 1'b0, 8'hFF, 1'b1, 1'b1, VEC));

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
